tick_run_controller: RTL



---
 rtl/tick_run_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tick_run_controller.sv
// Button front end for the seven-segment digit counter: synchronises and debounces
// run/clear buttons, runs the IDLE/RUNNING/PAUSED FSM and the one-second tick prescaler.
`timescale 1ns / 1ps

module tick_run_controller #(
  parameter int unsigned TICK_PERIOD = 1000,
  parameter int unsigned DEBOUNCE    = 20,
  parameter int unsigned CNT_W       = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_run,
  input  logic       btn_clear,
  output logic       run,
  output logic       tick,
  output logic       clear,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRunning = 2'b01,
    StPaused  = 2'b10,
    StInvalid = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DebLimit = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_PERIOD - 1);

  // Bit 0 carries the run button, bit 1 the clear button.
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            lvl_q, lvl_d, lvl_prev_q;
  logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            press;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      pre_q, pre_d;
  logic                  run_q, run_d;
  logic                  tick_q, tick_d;
  logic                  clear_q, clear_d;
  logic                  run_ev, clr_ev;

  assign btn_raw = {btn_clear, btn_run};

  // Press is taken from the registered level so the FSM sees it one cycle after acceptance.
  assign press  = lvl_q & ~lvl_prev_q;
  assign run_ev = press[0];
  assign clr_ev = press[1];

  always_comb begin
    lvl_d     = lvl_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (deb_cnt_q[i] + CNT_W'(1) == DebLimit) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    clear_d = clr_ev;
    if (clr_ev) begin
      // Clear wins over a coincident run press.
      state_d = StIdle;
      pre_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run_ev) state_d = StRunning;
        end
        StRunning: begin
          if (run_ev) begin
            state_d = StPaused;
          end else if (pre_q == TickLast) begin
            pre_d  = '0;
            tick_d = 1'b1;
          end else begin
            pre_d = pre_q + CNT_W'(1);
          end
        end
        StPaused: begin
          if (run_ev) state_d = StRunning;
        end
        default: state_d = StIdle;
      endcase
    end
    run_d = (state_d == StRunning);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      deb_cnt_q  <= '0;
      state_q    <= StIdle;
      pre_q      <= '0;
      run_q      <= 1'b0;
      tick_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      pre_q      <= pre_d;
      run_q      <= run_d;
      tick_q     <= tick_d;
      clear_q    <= clear_d;
    end
  end

  assign run   = run_q;
  assign tick  = tick_q;
  assign clear = clear_q;
  assign state = state_q;

endmodule
